// File: rtl/mbox_arb_pkg.sv
// Shared state encoding, sizing constants and index helper for the
// mailbox byte-port arbiter.
package mbox_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_WB_DW      = 32;
  localparam int unsigned DEF_WOU_DW     = 8;
  localparam int unsigned BYTES_PER_WORD = DEF_WB_DW / DEF_WOU_DW;

  // Requester indices are carried at the widest supported count.
  localparam int unsigned MAX_REQ    = 8;
  localparam int unsigned PTR_W      = 3;
  localparam int unsigned IDLE_CNT_W = 16;
  localparam int unsigned CNT_W      = 8;

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_REQ); i++) begin
      idx = oh[i] ? PTR_W'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mbox_arbiter_if.sv
// Requester word handshake and MAILBOX byte port of the arbiter.
interface mbox_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int WB_DW  = 32,
  parameter int WOU_DW = 8
);

  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ*WB_DW-1:0] req_dat_i;
  logic [NREQ-1:0]       req_last_i;
  logic [NREQ-1:0]       req_ready_o;
  logic                  mbox_wr_o;
  logic [WOU_DW-1:0]     mbox_do_o;
  logic                  mbox_full_i;
  logic [NREQ-1:0]       grant_o;
  logic                  busy_o;
  logic                  tmo_o;

  modport slave (
    input  req_valid_i, req_dat_i, req_last_i, mbox_full_i,
    output req_ready_o, mbox_wr_o, mbox_do_o, grant_o, busy_o, tmo_o
  );

  modport master (
    output req_valid_i, req_dat_i, req_last_i, mbox_full_i,
    input  req_ready_o, mbox_wr_o, mbox_do_o, grant_o, busy_o, tmo_o
  );

endinterface

// File: rtl/mbox_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above
// rr_ptr_i, wrapping modulo NREQ, returned one-hot.
module mbox_rr_pick
  import mbox_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  valid_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [NREQ-1:0]  winner_o
);

  logic found_s;
  logic hit_s;

  // Scan offsets from the pointer; only the first hit is kept.
  always_comb begin
    winner_o = '0;
    found_s  = 1'b0;
    hit_s    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        hit_s       = !found_s && valid_i[j] && (j == ((int'(rr_ptr_i) + k) % NREQ));
        winner_o[j] = winner_o[j] | hit_s;
        found_s     = found_s | hit_s;
      end
    end
  end

endmodule

// File: rtl/mbox_arbiter.sv
// Shares one MAILBOX byte port among NREQ word requesters: each accepted word
// is serialised LSB byte first, and a multi-word packet keeps the port locked.
module mbox_arbiter
  import mbox_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WB_DW    = 32,
  parameter int WOU_DW   = 8,
  parameter int HOLD_TMO = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  mbox_arbiter_if.slave bus
);

  localparam int unsigned BPW = WB_DW / WOU_DW;

  arb_state_e             state_q;
  logic [WB_DW-1:0]       buf_q;
  logic [CNT_W-1:0]       byte_cnt_q;
  logic [IDLE_CNT_W-1:0]  idle_cnt_q;
  logic [PTR_W-1:0]       rr_ptr_q;
  logic [PTR_W-1:0]       owner_q;
  logic [NREQ-1:0]        grant_q;
  logic                   last_q;
  logic                   tmo_q;

  logic [NREQ-1:0]        pick_s;
  logic [MAX_REQ-1:0]     pick_wide_s;
  logic [PTR_W-1:0]       pick_idx_s;
  logic [PTR_W-1:0]       next_ptr_s;
  logic [NREQ-1:0]        ready_raw_s;
  logic [NREQ-1:0]        ready_s;
  logic                   accept_s;
  logic [WB_DW-1:0]       word_s;
  logic                   word_last_s;
  logic                   wr_s;
  logic                   last_byte_s;
  logic                   hold_expire_s;

  mbox_rr_pick #(.NREQ(NREQ)) u_pick (
    .valid_i  (bus.req_valid_i),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (pick_s)
  );

  // Handshake decode, one-hot word mux and byte-write strobe.
  always_comb begin
    pick_wide_s              = '0;
    pick_wide_s[NREQ-1:0]    = pick_s;
    pick_idx_s               = onehot_to_idx(pick_wide_s);
    next_ptr_s               = (owner_q == PTR_W'(NREQ-1)) ? '0 : owner_q + PTR_W'(1);

    case (state_q)
      ST_IDLE: ready_raw_s = pick_s;
      ST_HOLD: ready_raw_s = grant_q;
      default: ready_raw_s = '0;
    endcase
    // Ready must be low for the whole reset pulse, not only after an edge.
    ready_s  = wb_rst_i ? '0 : ready_raw_s;
    accept_s = |(bus.req_valid_i & ready_s);

    word_s      = '0;
    word_last_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      word_s      = word_s | (bus.req_dat_i[i*WB_DW +: WB_DW] & {WB_DW{ready_s[i]}});
      word_last_s = word_last_s | (bus.req_last_i[i] & ready_s[i]);
    end

    wr_s          = (state_q == ST_SHIFT) && !bus.mbox_full_i;
    last_byte_s   = (byte_cnt_q == CNT_W'(BPW-1));
    hold_expire_s = (idle_cnt_q == IDLE_CNT_W'(HOLD_TMO-1));
  end

  // Arbiter state machine: load a word, shift it out, lock or release.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      last_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            buf_q      <= word_s;
            last_q     <= word_last_s;
            owner_q    <= pick_idx_s;
            grant_q    <= pick_s;
            byte_cnt_q <= '0;
            state_q    <= ST_SHIFT;
          end else begin
            state_q    <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (wr_s) begin
            buf_q <= buf_q >> WOU_DW;
            if (last_byte_s) begin
              byte_cnt_q <= '0;
              idle_cnt_q <= '0;
              if (last_q) begin
                state_q  <= ST_IDLE;
                rr_ptr_q <= next_ptr_s;
                grant_q  <= '0;
              end else begin
                state_q  <= ST_HOLD;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            end
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_HOLD: begin
          if (accept_s) begin
            buf_q      <= word_s;
            last_q     <= word_last_s;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            state_q    <= ST_SHIFT;
          end else if (hold_expire_s) begin
            state_q    <= ST_IDLE;
            tmo_q      <= 1'b1;
            idle_cnt_q <= '0;
            rr_ptr_q   <= next_ptr_s;
            grant_q    <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + IDLE_CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready_o = ready_s;
  assign bus.mbox_wr_o   = wr_s;
  assign bus.mbox_do_o   = buf_q[WOU_DW-1:0];
  assign bus.grant_o     = grant_q;
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.tmo_o       = tmo_q;

endmodule

// File: doc/mbox_arbiter.md
MBOX_ARBITER -- requirements
Module: mbox_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of word requesters sharing the MAILBOX byte port (2..8).
REQ-002 Parameter WB_DW, default 32, requester word width; SHALL be a multiple of WOU_DW.
REQ-003 Parameter WOU_DW, default 8, MAILBOX byte width.
REQ-004 Parameter HOLD_TMO, default 255, maximum idle cycles in HOLD before a forced release.
REQ-005 wb_clk_i  in  1  sole clock; all logic is on the rising edge.
REQ-006 wb_rst_i  in  1  asynchronous, active-high reset.
REQ-007 req_valid_i  in  NREQ  per-requester word valid.
REQ-008 req_dat_i  in  NREQ*WB_DW  word data; requester i occupies bits [i*WB_DW +: WB_DW].
REQ-009 req_last_i  in  NREQ  marks the final word of a packet; sampled with the word.
REQ-010 req_ready_o  out  NREQ  word accepted on the cycle where valid&ready are both high.
REQ-011 mbox_wr_o  out  1  MAILBOX byte write strobe.
REQ-012 mbox_do_o  out  WOU_DW  MAILBOX byte data.
REQ-013 mbox_full_i  in  1  MAILBOX full; a byte is not written while it is high.
REQ-014 grant_o  out  NREQ  one-hot current owner; zero in IDLE.
REQ-015 busy_o  out  1  high in any state other than IDLE.
REQ-016 tmo_o  out  1  single-cycle pulse on a HOLD timeout release.

Function
REQ-017 States SHALL be IDLE, SHIFT and HOLD.
REQ-018 IDLE: the winner SHALL be the first requester with valid high, scanning from rr_ptr upward modulo NREQ; only the winner's req_ready_o SHALL be high, combinationally in the same cycle.
REQ-019 On acceptance, the word SHALL be loaded into the shift buffer, last_q SHALL capture req_last_i, the owner SHALL be registered, and the state SHALL go to SHIFT.
REQ-020 SHIFT: mbox_wr_o SHALL equal ~mbox_full_i; mbox_do_o SHALL equal buf[WOU_DW-1:0], least-significant byte first.
REQ-021 Each cycle with mbox_wr_o high SHALL shift the buffer right by WOU_DW and increment the byte count.
REQ-022 While mbox_full_i is high, the buffer, byte count and mbox_do_o SHALL hold.
REQ-023 After byte WB_DW/WOU_DW is written: if last_q is set, the state SHALL go to IDLE and rr_ptr SHALL become owner+1 modulo NREQ; otherwise the state SHALL go to HOLD.
REQ-024 HOLD: req_ready_o SHALL be high for the owner only; an accept SHALL reload the buffer as in REQ-019 and return to SHIFT.
REQ-025 HOLD: other requesters SHALL never be granted (packet lock).
REQ-026 HOLD: an idle counter SHALL increment each cycle without an accept.
REQ-027 When the idle counter reaches HOLD_TMO, the block SHALL go to IDLE, pulse tmo_o, and advance rr_ptr as in REQ-023.
REQ-028 Minimum word throughput SHALL be 5 cycles/word: 1 accept cycle plus 4 byte cycles, with mbox_full_i low.
REQ-029 No byte SHALL be dropped or duplicated under any mbox_full_i pattern.
REQ-030 mbox_wr_o SHALL never be high outside SHIFT.
REQ-031 A requester deasserting valid without an accept SHALL have no effect.
REQ-032 req_last_i SHALL be ignored unless valid and ready are both high.

Reset
REQ-033 On wb_rst_i high, the following SHALL be forced immediately, without waiting for a clock edge: state IDLE, buffer 0, byte count 0, idle counter 0, rr_ptr 0, last_q 0, owner 0.
REQ-034 Resulting output values during reset: mbox_wr_o=0, mbox_do_o=0, req_ready_o=0, grant_o=0, busy_o=0, tmo_o=0.
REQ-035 Reset mid-packet SHALL abandon the partial word; no further bytes SHALL be emitted for it.

Structure
REQ-036 Package mbox_arb_pkg SHALL hold the state encoding and the BYTES_PER_WORD constant (WB_DW/WOU_DW).
REQ-037 Round-robin selection SHALL be a sub-module mbox_rr_pick with inputs (valid vector, rr_ptr) and output one-hot winner; it SHALL be purely combinational.

Verification
REQ-038 Single word: requester 0 sends 0x11223344 with last=1, full low -> bytes 44,33,22,11 on 4 consecutive cycles; then IDLE; rr_ptr=1.
REQ-039 Contention: all four requesters valid with single-word packets -> grant order 0,1,2,3,0; each word is emitted intact.
REQ-040 Packet lock: requester 2 sends 3 words (last on the 3rd) while requester 1 is valid throughout -> all 12 bytes from requester 2 precede any byte from requester 1.
REQ-041 Backpressure: mbox_full_i high for 3 cycles after byte 2 of 0xAABBCCDD -> mbox_do_o holds 0xBB; sequence DD,CC,BB,AA with no duplicates.
REQ-042 Timeout: HOLD_TMO=10, owner idles after a non-last word -> tmo_o pulses 10 cycles after HOLD entry; next requester is granted.
REQ-043 Async reset asserted after byte 1 -> mbox_wr_o low immediately; after release, a new word emits all 4 bytes.
